cavlc_param_fifo: RTL and testbench

Parametrised synchronous FIFO for the CAVLC datapath. It generalises the fixed 16-bit, 8-entry coefficient FIFO to configurable width, depth and almost-full/almost-empty thresholds. All DEPTH entries are usable, and a read can make room for a write in the same cycle. It adds an occupancy output and sticky error flags, and sits between coefficient producers and the CAVLC encoder/decoder engines.

---
 rtl/cavlc_param_fifo_if.sv | 34 +++
 rtl/cavlc_param_fifo.sv | 93 +++++++++
 tb/tb_cavlc_param_fifo.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cavlc_param_fifo_if.sv
// Handshake and status bundle between a coefficient producer/consumer and cavlc_param_fifo.
interface cavlc_param_fifo_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    logic             DataReady;
    logic [WIDTH-1:0] DataIn;
    logic             ReadFIFO;
    logic             ErrClear;
    logic [WIDTH-1:0] DataOut;
    logic [LW-1:0]    Level;
    logic             Full;
    logic             AlmostFull;
    logic             Empty;
    logic             AlmostEmpty;
    logic             Overflow;
    logic             Underflow;
    logic             OverflowSticky;
    logic             UnderflowSticky;

    modport master (
        output DataReady, DataIn, ReadFIFO, ErrClear,
        input  DataOut, Level, Full, AlmostFull, Empty, AlmostEmpty,
               Overflow, Underflow, OverflowSticky, UnderflowSticky
    );

    modport slave (
        input  DataReady, DataIn, ReadFIFO, ErrClear,
        output DataOut, Level, Full, AlmostFull, Empty, AlmostEmpty,
               Overflow, Underflow, OverflowSticky, UnderflowSticky
    );
endinterface

// File: rtl/cavlc_param_fifo.sv
// Parametrised show-ahead FIFO for the CAVLC datapath, with occupancy, thresholds
// and pulsed/sticky overflow and underflow reporting.
module cavlc_param_fifo #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 3,
    parameter int AE_LEVEL = 1
) (
    input  logic               Clk,
    input  logic               nReset,
    input  logic               Enable,
    cavlc_param_fifo_if.slave  fifoBus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [LW-1:0]    level;
    logic             full;
    logic             empty;
    logic             wrAcc;
    logic             rdAcc;
    logic             ovfCond;
    logic             unfCond;
    logic             ovfPulse;
    logic             unfPulse;
    logic             ovfSticky;
    logic             unfSticky;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // A read frees a slot in the same cycle, so a write is accepted at Full
    // only when paired with a read; at Empty the read is refused.
    assign wrAcc   = fifoBus.DataReady & (~full | fifoBus.ReadFIFO);
    assign rdAcc   = fifoBus.ReadFIFO & ~empty;
    assign ovfCond = fifoBus.DataReady & full & ~fifoBus.ReadFIFO;
    assign unfCond = fifoBus.ReadFIFO & empty;

    always_ff @(posedge Clk) begin
        if (Enable && wrAcc) begin
            mem[wrPtr] <= fifoBus.DataIn;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            level     <= '0;
            ovfPulse  <= 1'b0;
            unfPulse  <= 1'b0;
            ovfSticky <= 1'b0;
            unfSticky <= 1'b0;
        end else if (!Enable) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            level     <= '0;
            ovfPulse  <= 1'b0;
            unfPulse  <= 1'b0;
            ovfSticky <= 1'b0;
            unfSticky <= 1'b0;
        end else begin
            if (wrAcc) wrPtr <= wrPtr + 1'b1;
            if (rdAcc) rdPtr <= rdPtr + 1'b1;
            case ({wrAcc, rdAcc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            ovfPulse <= ovfCond;
            unfPulse <= unfCond;
            // A fresh error outranks a simultaneous clear.
            if (ovfCond)                  ovfSticky <= 1'b1;
            else if (fifoBus.ErrClear)    ovfSticky <= 1'b0;
            if (unfCond)                  unfSticky <= 1'b1;
            else if (fifoBus.ErrClear)    unfSticky <= 1'b0;
        end
    end

    assign fifoBus.DataOut         = empty ? '0 : mem[rdPtr];
    assign fifoBus.Level           = level;
    assign fifoBus.Full            = full;
    assign fifoBus.Empty           = empty;
    assign fifoBus.AlmostFull      = (level >= LW'(AF_LEVEL));
    assign fifoBus.AlmostEmpty     = (level <= LW'(AE_LEVEL));
    assign fifoBus.Overflow        = ovfPulse;
    assign fifoBus.Underflow       = unfPulse;
    assign fifoBus.OverflowSticky  = ovfSticky;
    assign fifoBus.UnderflowSticky = unfSticky;
endmodule

// File: tb/tb_cavlc_param_fifo.sv
// Scoreboard bench for cavlc_param_fifo at WIDTH=16, DEPTH=8.
module tb_cavlc_param_fifo;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic Clk = 1'b0;
    logic nReset = 1'b0;
    logic Enable = 1'b1;

    cavlc_param_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifoBus ();

    cavlc_param_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(5), .AE_LEVEL(1)
    ) dut (
        .Clk(Clk), .nReset(nReset), .Enable(Enable), .fifoBus(fifoBus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb [$];
    int mLevel = 0;
    logic mOvf = 0, mUnf = 0, mOvfS = 0, mUnfS = 0;

    // Drives one cycle of requests, updates the model; reports head word seen
    // before the edge and the word the scoreboard expected to pop.
    task automatic drive(input logic dr, input logic [15:0] din, input logic rd,
                         output logic popped, output logic [15:0] obs,
                         output logic [15:0] exp);
        logic wa, ra, oc, uc;
        fifoBus.DataReady = dr;
        fifoBus.DataIn    = din;
        fifoBus.ReadFIFO  = rd;
        #1;
        obs = fifoBus.DataOut;
        popped = 1'b0;
        exp = '0;
        wa = dr && (mLevel < DEPTH || rd);
        ra = rd && (mLevel > 0);
        oc = dr && (mLevel == DEPTH) && !rd;
        uc = rd && (mLevel == 0);
        @(posedge Clk);
        #1;
        if (!Enable) begin
            sb.delete();
            mLevel = 0; mOvf = 0; mUnf = 0; mOvfS = 0; mUnfS = 0;
        end else begin
            if (ra) begin
                exp = sb.pop_front();
                popped = 1'b1;
            end
            if (wa) sb.push_back(din);
            if (wa && !ra) mLevel++;
            if (ra && !wa) mLevel--;
            mOvf = oc;
            mUnf = uc;
            if (oc) mOvfS = 1; else if (fifoBus.ErrClear) mOvfS = 0;
            if (uc) mUnfS = 1; else if (fifoBus.ErrClear) mUnfS = 0;
        end
        fifoBus.DataReady = 1'b0;
        fifoBus.ReadFIFO  = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (fifoBus.Level !== 4'd0 || fifoBus.Empty !== 1'b1 || fifoBus.AlmostEmpty !== 1'b1 ||
            fifoBus.Full !== 1'b0 || fifoBus.AlmostFull !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags level=%0d E=%b AE=%b F=%b AF=%b need 0 1 1 0 0",
                     fifoBus.Level, fifoBus.Empty, fifoBus.AlmostEmpty, fifoBus.Full, fifoBus.AlmostFull);
        end
        checks++;
        if (fifoBus.DataOut !== 16'h0 || fifoBus.Overflow !== 1'b0 || fifoBus.Underflow !== 1'b0 ||
            fifoBus.OverflowSticky !== 1'b0 || fifoBus.UnderflowSticky !== 1'b0) begin
            errors++;
            $display("FAIL reset_data dout=%h ovf=%b unf=%b ovfs=%b unfs=%b need all 0",
                     fifoBus.DataOut, fifoBus.Overflow, fifoBus.Underflow,
                     fifoBus.OverflowSticky, fifoBus.UnderflowSticky);
        end
    endtask

    task automatic test_fill();
        logic p; logic [15:0] o, e;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(i), 1'b0, p, o, e);
            checks++;
            if (fifoBus.Level !== 4'(i) || fifoBus.AlmostFull !== (i >= 5) ||
                fifoBus.Full !== (i == 8) || fifoBus.Empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d level=%0d AF=%b F=%b E=%b need %0d %b %b 0", i,
                         fifoBus.Level, fifoBus.AlmostFull, fifoBus.Full, fifoBus.Empty,
                         i, (i >= 5), (i == 8));
            end
            checks++;
            if (fifoBus.DataOut !== 16'h0001) begin
                errors++;
                $display("FAIL fill_head_%0d dout=%h need 0001", i, fifoBus.DataOut);
            end
        end
    endtask

    task automatic test_rw_full();
        logic p; logic [15:0] o, e;
        drive(1'b1, 16'h00AA, 1'b1, p, o, e);
        checks++;
        if (!p || o !== e) begin
            errors++;
            $display("FAIL rwfull_pop popped=%b dout=%h need %h", p, o, e);
        end
        checks++;
        if (fifoBus.Level !== 4'd8 || fifoBus.Overflow !== 1'b0 || fifoBus.DataOut !== 16'h0002) begin
            errors++;
            $display("FAIL rwfull_state level=%0d ovf=%b dout=%h need 8 0 0002",
                     fifoBus.Level, fifoBus.Overflow, fifoBus.DataOut);
        end
    endtask

    task automatic test_overflow();
        logic p; logic [15:0] o, e;
        drive(1'b1, 16'h0099, 1'b0, p, o, e);
        checks++;
        if (fifoBus.Level !== 4'd8 || fifoBus.Overflow !== 1'b1 || fifoBus.OverflowSticky !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pulse level=%0d ovf=%b ovfs=%b need 8 1 1",
                     fifoBus.Level, fifoBus.Overflow, fifoBus.OverflowSticky);
        end
        drive(1'b0, 16'h0, 1'b0, p, o, e);
        checks++;
        if (fifoBus.Overflow !== 1'b0 || fifoBus.OverflowSticky !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold ovf=%b ovfs=%b need 0 1", fifoBus.Overflow, fifoBus.OverflowSticky);
        end
        fifoBus.ErrClear = 1'b1;
        drive(1'b0, 16'h0, 1'b0, p, o, e);
        fifoBus.ErrClear = 1'b0;
        checks++;
        if (fifoBus.OverflowSticky !== mOvfS || mOvfS !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear ovfs=%b need 0", fifoBus.OverflowSticky);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 16'h0, 1'b1, p, o, e);
            checks++;
            if (!p || o !== e || fifoBus.Level !== 4'(mLevel)) begin
                errors++;
                $display("FAIL drain_%0d dout=%h need %h level=%0d need %0d",
                         i, o, e, fifoBus.Level, mLevel);
            end
        end
        checks++;
        if (e !== 16'h00AA || fifoBus.Empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_last word=%h need 00aa empty=%b", e, fifoBus.Empty);
        end
    endtask

    task automatic test_empty();
        logic p; logic [15:0] o, e;
        drive(1'b0, 16'h0, 1'b1, p, o, e);
        checks++;
        if (fifoBus.Underflow !== 1'b1 || fifoBus.DataOut !== 16'h0 || fifoBus.Level !== 4'd0) begin
            errors++;
            $display("FAIL unf_read unf=%b dout=%h level=%0d need 1 0000 0",
                     fifoBus.Underflow, fifoBus.DataOut, fifoBus.Level);
        end
        drive(1'b1, 16'h1234, 1'b1, p, o, e);
        checks++;
        if (fifoBus.Level !== 4'd1 || fifoBus.DataOut !== 16'h1234 || fifoBus.Underflow !== 1'b1 || p) begin
            errors++;
            $display("FAIL unf_rw level=%0d dout=%h unf=%b need 1 1234 1",
                     fifoBus.Level, fifoBus.DataOut, fifoBus.Underflow);
        end
        drive(1'b0, 16'h0, 1'b0, p, o, e);
        checks++;
        if (fifoBus.Underflow !== 1'b0 || fifoBus.UnderflowSticky !== 1'b1) begin
            errors++;
            $display("FAIL unf_hold unf=%b unfs=%b need 0 1", fifoBus.Underflow, fifoBus.UnderflowSticky);
        end
        drive(1'b0, 16'h0, 1'b1, p, o, e);
        checks++;
        if (!p || o !== 16'h1234 || fifoBus.Empty !== 1'b1) begin
            errors++;
            $display("FAIL unf_pop dout=%h need 1234 empty=%b", o, fifoBus.Empty);
        end
        fifoBus.ErrClear = 1'b1;
        drive(1'b0, 16'h0, 1'b1, p, o, e);
        fifoBus.ErrClear = 1'b0;
        checks++;
        if (fifoBus.UnderflowSticky !== 1'b1) begin
            errors++;
            $display("FAIL unf_setwins unfs=%b need 1", fifoBus.UnderflowSticky);
        end
        fifoBus.ErrClear = 1'b1;
        drive(1'b0, 16'h0, 1'b0, p, o, e);
        fifoBus.ErrClear = 1'b0;
        checks++;
        if (fifoBus.UnderflowSticky !== 1'b0) begin
            errors++;
            $display("FAIL unf_clear unfs=%b need 0", fifoBus.UnderflowSticky);
        end
    endtask

    task automatic test_wrap();
        logic p; logic [15:0] o, e;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 16'h5A00 + 16'(k), 1'b0, p, o, e);
            checks++;
            if (fifoBus.Level > 4'd1 || fifoBus.AlmostEmpty !== 1'b1 || fifoBus.DataOut !== 16'h5A00 + 16'(k)) begin
                errors++;
                $display("FAIL wrap_wr_%0d level=%0d AE=%b dout=%h", k,
                         fifoBus.Level, fifoBus.AlmostEmpty, fifoBus.DataOut);
            end
            drive(1'b0, 16'h0, 1'b1, p, o, e);
            checks++;
            if (!p || o !== e || fifoBus.Level !== 4'd0 || fifoBus.AlmostEmpty !== 1'b1) begin
                errors++;
                $display("FAIL wrap_rd_%0d dout=%h need %h level=%0d", k, o, e, fifoBus.Level);
            end
        end
        // Back-to-back write+read at level 1 after the pointer wrap.
        drive(1'b1, 16'hC000, 1'b0, p, o, e);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 16'hC000 + 16'(k), 1'b1, p, o, e);
            checks++;
            if (!p || o !== e || fifoBus.Level !== 4'd1 || fifoBus.DataOut !== 16'hC000 + 16'(k)) begin
                errors++;
                $display("FAIL b2b_%0d dout=%h need %h level=%0d", k, o, e, fifoBus.Level);
            end
        end
        drive(1'b0, 16'h0, 1'b1, p, o, e);
    endtask

    task automatic test_enable();
        logic p; logic [15:0] o, e;
        for (int i = 0; i < 9; i++) drive(1'b1, 16'h0700 + 16'(i), 1'b0, p, o, e);
        for (int i = 0; i < 3; i++) drive(1'b0, 16'h0, 1'b1, p, o, e);
        checks++;
        if (fifoBus.Level !== 4'd5 || fifoBus.OverflowSticky !== 1'b1) begin
            errors++;
            $display("FAIL en_setup level=%0d ovfs=%b need 5 1", fifoBus.Level, fifoBus.OverflowSticky);
        end
        Enable = 1'b0;
        drive(1'b1, 16'hDEAD, 1'b1, p, o, e);
        Enable = 1'b1;
        checks++;
        if (fifoBus.Level !== 4'd0 || fifoBus.Empty !== 1'b1 || fifoBus.OverflowSticky !== 1'b0 ||
            fifoBus.UnderflowSticky !== 1'b0 || fifoBus.DataOut !== 16'h0) begin
            errors++;
            $display("FAIL en_clear level=%0d E=%b ovfs=%b unfs=%b dout=%h need 0 1 0 0 0000",
                     fifoBus.Level, fifoBus.Empty, fifoBus.OverflowSticky,
                     fifoBus.UnderflowSticky, fifoBus.DataOut);
        end
    endtask

    task automatic test_async_reset();
        logic p; logic [15:0] o, e;
        for (int i = 0; i < 3; i++) drive(1'b1, 16'h0B00 + 16'(i), 1'b0, p, o, e);
        fifoBus.DataReady = 1'b1;
        fifoBus.DataIn    = 16'h0BFF;
        #2;
        nReset = 1'b0;
        #1;
        checks++;
        if (fifoBus.Level !== 4'd0 || fifoBus.Empty !== 1'b1 || fifoBus.DataOut !== 16'h0) begin
            errors++;
            $display("FAIL async_rst level=%0d E=%b dout=%h need 0 1 0000",
                     fifoBus.Level, fifoBus.Empty, fifoBus.DataOut);
        end
        fifoBus.DataReady = 1'b0;
        sb.delete();
        mLevel = 0; mOvf = 0; mUnf = 0; mOvfS = 0; mUnfS = 0;
        @(negedge Clk);
        nReset = 1'b1;
        drive(1'b1, 16'h0C0C, 1'b0, p, o, e);
        drive(1'b0, 16'h0, 1'b1, p, o, e);
        checks++;
        if (!p || o !== 16'h0C0C || fifoBus.Level !== 4'd0) begin
            errors++;
            $display("FAIL post_rst dout=%h need 0c0c level=%0d", o, fifoBus.Level);
        end
    endtask

    initial begin
        fifoBus.DataReady = 1'b0;
        fifoBus.DataIn    = '0;
        fifoBus.ReadFIFO  = 1'b0;
        fifoBus.ErrClear  = 1'b0;
        #12;
        test_reset();
        @(negedge Clk);
        nReset = 1'b1;
        @(posedge Clk);
        #1;
        test_fill();
        test_rw_full();
        test_overflow();
        test_empty();
        test_wrap();
        test_enable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
